// File: rtl/writeback_regfile_pkg.sv
// Shared Y86-64 write-back definitions: widths, status codes, register/icode IDs, write-port payload.
package writeback_regfile_pkg;

  localparam int unsigned DATA_WID   = 64;
  localparam int unsigned NREG       = 15;
  localparam int unsigned CNT_WID    = 32;
  localparam int unsigned REG_ID_WID = 4;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IRRMOVQ = 4'h2;

  localparam logic [REG_ID_WID-1:0] RRSP  = 4'h4;
  localparam logic [REG_ID_WID-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic                  en;
    logic [REG_ID_WID-1:0] id;
    logic [DATA_WID-1:0]   data;
  } wr_port_t;

endpackage

// File: rtl/writeback_regfile_core.sv
// 15-entry program register file: two combinational read ports, two write ports, M wins over E.
module writeback_regfile_core
  import writeback_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  wr_port_t              e_wr,
  input  wr_port_t              m_wr,
  input  logic [REG_ID_WID-1:0] src_a,
  input  logic [REG_ID_WID-1:0] src_b,
  output logic [DATA_WID-1:0]   rd_a,
  output logic [DATA_WID-1:0]   rd_b
);

  logic [DATA_WID-1:0] regs [NREG];

  // IDs outside 0..NREG-1 (RNONE) match no entry, so such writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (m_wr.en && m_wr.id == REG_ID_WID'(i))
          regs[i] <= m_wr.data;
        else if (e_wr.en && e_wr.id == REG_ID_WID'(i))
          regs[i] <= e_wr.data;
      end
    end
  end

  // Match-based read: RNONE hits nothing and reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == REG_ID_WID'(i)) rd_a = regs[i];
      if (src_b == REG_ID_WID'(i)) rd_b = regs[i];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: commit gating, cmov suppression, status/halt latch, retire counter.
// Optional same-cycle read forwarding of the committing data when WB_BYPASS_EN is defined.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en,
  input  logic [3:0]          icode,
  input  logic                cnd,
  input  logic [3:0]          stat_in,
  input  logic [3:0]          dstE,
  input  logic [3:0]          dstM,
  input  logic [DATA_WID-1:0] valE,
  input  logic [DATA_WID-1:0] valM,
  input  logic [3:0]          srcA,
  input  logic [3:0]          srcB,
  output logic [DATA_WID-1:0] rvalA,
  output logic [DATA_WID-1:0] rvalB,
  output logic [3:0]          stat,
  output logic                halted,
  output logic [CNT_WID-1:0]  retired
);

  logic                commit;
  logic                aok;
  wr_port_t            e_wr;
  wr_port_t            m_wr;
  logic [DATA_WID-1:0] rd_a;
  logic [DATA_WID-1:0] rd_b;

  // Write enables carry every gating rule so the bypass path can reuse them directly.
  always_comb begin
    commit    = wb_en && !halted;
    aok       = (stat_in == SAOK);
    e_wr.en   = commit && aok && (dstE != RNONE) && !((icode == IRRMOVQ) && !cnd);
    e_wr.id   = dstE;
    e_wr.data = valE;
    m_wr.en   = commit && aok && (dstM != RNONE);
    m_wr.id   = dstM;
    m_wr.data = valM;
  end

  writeback_regfile_core u_core (
    .clk   (clk),
    .rst   (rst),
    .e_wr  (e_wr),
    .m_wr  (m_wr),
    .src_a (srcA),
    .src_b (srcB),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  // A non-AOK status freezes the machine; only HLT counts as a retired instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat    <= SAOK;
      halted  <= 1'b0;
      retired <= '0;
    end else if (commit) begin
      if (aok) begin
        retired <= retired + CNT_WID'(1);
      end else begin
        stat   <= stat_in;
        halted <= 1'b1;
        if (stat_in == SHLT) retired <= retired + CNT_WID'(1);
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rvalA = rd_a;
    rvalB = rd_b;
    if (m_wr.en && m_wr.id == srcA)      rvalA = valM;
    else if (e_wr.en && e_wr.id == srcA) rvalA = valE;
    if (m_wr.en && m_wr.id == srcB)      rvalB = valM;
    else if (e_wr.en && e_wr.id == srcB) rvalB = valE;
  end
`else
  always_comb begin
    rvalA = rd_a;
    rvalB = rd_b;
  end
`endif

endmodule
